dmem_arbiter: RTL and testbench

// Two-requester arbiter/sequencer in front of DataMemory (single port: MemRead/MemWrite/a/wd/rd).

---
 rtl/dmem_pkg.sv | 11 +
 rtl/dmem_rr_arbiter.sv | 29 ++
 rtl/dmem_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and default widths for the DataMemory arbiter.
package dmem_pkg;

   localparam int unsigned DM_ADDRESS_DEF = 9;
   localparam int unsigned DATA_W_DEF     = 32;

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} dmem_state_e;

   typedef enum logic {GNT_CORE, GNT_DBG} dmem_gnt_e;

endpackage

// File: rtl/dmem_rr_arbiter.sv
// Two-way request arbiter: req[0] = core, req[1] = debug; one-hot grant when enabled.
module dmem_rr_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned PRIORITY = 0
) (
   input  logic [1:0] i_req,
   input  dmem_gnt_e  i_last_grant,
   input  logic       i_enable,
   output logic [1:0] o_gnt
);

   always_comb begin
      o_gnt = 2'b00;
      if (i_enable) begin
         unique case (i_req)
            2'b01: o_gnt = 2'b01;
            2'b10: o_gnt = 2'b10;
            2'b11: begin
               // Fixed priority favours core; round-robin favours whoever did not win last.
               if (PRIORITY != 0 || i_last_grant == GNT_DBG) o_gnt = 2'b01;
               else                                          o_gnt = 2'b10;
            end
            default: o_gnt = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Sequences core and debug requests onto the single DataMemory port, one transaction at a time.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned DM_ADDRESS = DM_ADDRESS_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned PRIORITY   = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  c_req_valid,
   output logic                  c_req_ready,
   input  logic                  c_req_we,
   input  logic [DM_ADDRESS-1:0] c_req_addr,
   input  logic [DATA_W-1:0]     c_req_wdata,
   output logic                  c_rsp_valid,
   input  logic                  c_rsp_ready,
   output logic [DATA_W-1:0]     c_rsp_rdata,
   input  logic                  d_req_valid,
   output logic                  d_req_ready,
   input  logic                  d_req_we,
   input  logic [DM_ADDRESS-1:0] d_req_addr,
   input  logic [DATA_W-1:0]     d_req_wdata,
   output logic                  d_rsp_valid,
   input  logic                  d_rsp_ready,
   output logic [DATA_W-1:0]     d_rsp_rdata,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [DM_ADDRESS-1:0] mem_a,
   output logic [DATA_W-1:0]     mem_wd,
   input  logic [DATA_W-1:0]     mem_rd
);

   dmem_state_e           r_state;
   dmem_state_e           w_state_d;
   dmem_gnt_e             r_gnt;
   logic                  r_we;
   logic [DM_ADDRESS-1:0] r_addr;
   logic [DATA_W-1:0]     r_wdata;
   logic [DATA_W-1:0]     r_rdata;
   logic [1:0]            w_gnt;
   logic                  w_hs;
   logic                  w_access;
   logic                  w_rsp_ready;

   // Ready is held off while reset is asserted so nothing is accepted on the reset edge.
   dmem_rr_arbiter #(
      .PRIORITY (PRIORITY)
   ) u_arb (
      .i_req        ({d_req_valid, c_req_valid}),
      .i_last_grant (r_gnt),
      .i_enable     ((r_state == ST_IDLE) && rst_n),
      .o_gnt        (w_gnt)
   );

   assign w_hs        = |w_gnt;
   assign c_req_ready = w_gnt[0];
   assign d_req_ready = w_gnt[1];
   assign w_access    = (r_state == ST_ACCESS);
   assign w_rsp_ready = (r_gnt == GNT_CORE) ? c_rsp_ready : d_rsp_ready;

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         ST_IDLE:   if (w_hs) w_state_d = ST_ACCESS;
         ST_ACCESS: w_state_d = ST_RESP;
         ST_RESP:   if (w_rsp_ready) w_state_d = ST_IDLE;
         default:   w_state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_d;
   end

   // r_gnt is both the in-flight grant id and the round-robin history.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_gnt   <= GNT_CORE;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         if (w_hs) begin
            r_gnt   <= w_gnt[1] ? GNT_DBG : GNT_CORE;
            r_we    <= w_gnt[1] ? d_req_we    : c_req_we;
            r_addr  <= w_gnt[1] ? d_req_addr  : c_req_addr;
            r_wdata <= w_gnt[1] ? d_req_wdata : c_req_wdata;
         end
         if (w_access) r_rdata <= r_we ? '0 : mem_rd;
      end
   end

   assign mem_read    = w_access & ~r_we;
   assign mem_write   = w_access & r_we;
   assign mem_a       = w_access ? r_addr : '0;
   assign mem_wd      = (w_access & r_we) ? r_wdata : '0;

   assign c_rsp_valid = (r_state == ST_RESP) && (r_gnt == GNT_CORE);
   assign d_rsp_valid = (r_state == ST_RESP) && (r_gnt == GNT_DBG);
   assign c_rsp_rdata = c_rsp_valid ? r_rdata : '0;
   assign d_rsp_rdata = d_rsp_valid ? r_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: table of single transactions plus multi-cycle corner sequences.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Round-robin instance (PRIORITY=0) with a behavioural DataMemory.
   logic        rst_n = 1'b0;
   logic        c_req_valid = 0, c_req_we = 0, c_rsp_ready = 0;
   logic [8:0]  c_req_addr = 0;
   logic [31:0] c_req_wdata = 0;
   logic        d_req_valid = 0, d_req_we = 0, d_rsp_ready = 0;
   logic [8:0]  d_req_addr = 0;
   logic [31:0] d_req_wdata = 0;
   logic        c_req_ready, c_rsp_valid, d_req_ready, d_rsp_valid;
   logic [31:0] c_rsp_rdata, d_rsp_rdata;
   logic        mem_read, mem_write;
   logic [8:0]  mem_a;
   logic [31:0] mem_wd, mem_rd;

   logic [31:0] mem [0:511];
   logic        pl_en = 0;
   logic [8:0]  pl_a = 0;
   logic [31:0] pl_d = 0;
   int          wr_cnt = 0;

   always @(posedge clk) begin
      if (mem_write) mem[mem_a] <= mem_wd;
      else if (pl_en) mem[pl_a] <= pl_d;
      if (mem_write) wr_cnt <= wr_cnt + 1;
   end
   assign mem_rd = mem[mem_a];

   dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .PRIORITY(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
      .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata), .c_rsp_valid(c_rsp_valid),
      .c_rsp_ready(c_rsp_ready), .c_rsp_rdata(c_rsp_rdata),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
      .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_rsp_valid(d_rsp_valid),
      .d_rsp_ready(d_rsp_ready), .d_rsp_rdata(d_rsp_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_a(mem_a), .mem_wd(mem_wd),
      .mem_rd(mem_rd)
   );

   // Fixed-priority instance; only its grant behaviour is examined.
   logic        p_rst_n = 1'b0;
   logic        p_c_valid = 0, p_d_valid = 0;
   logic        p_c_ready, p_d_ready, p_c_rsp_valid, p_d_rsp_valid;
   logic [31:0] p_c_rdata, p_d_rdata, p_wd;
   logic        p_mem_read, p_mem_write;
   logic [8:0]  p_mem_a;

   dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .PRIORITY(1)) dut_fp (
      .clk(clk), .rst_n(p_rst_n),
      .c_req_valid(p_c_valid), .c_req_ready(p_c_ready), .c_req_we(1'b0),
      .c_req_addr(9'h001), .c_req_wdata(32'h0), .c_rsp_valid(p_c_rsp_valid),
      .c_rsp_ready(1'b1), .c_rsp_rdata(p_c_rdata),
      .d_req_valid(p_d_valid), .d_req_ready(p_d_ready), .d_req_we(1'b0),
      .d_req_addr(9'h002), .d_req_wdata(32'h0), .d_rsp_valid(p_d_rsp_valid),
      .d_rsp_ready(1'b1), .d_rsp_rdata(p_d_rdata),
      .mem_read(p_mem_read), .mem_write(p_mem_write), .mem_a(p_mem_a), .mem_wd(p_wd),
      .mem_rd(32'h0)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Bounded wait for the selected requester's req_ready, sampled on the falling edge.
   task automatic wait_ready(input bit dbg, input string name);
      bit got = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if ((dbg ? d_req_ready : c_req_ready) === 1'b1) begin
            got = 1;
            break;
         end
      end
      check({name, "_ready"}, 32'(got), 32'd1);
   endtask

   // One full transaction with rsp_ready high; checks the ACCESS and RESP cycles.
   task automatic txn(input bit dbg, input bit we, input logic [8:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input string name);
      if (dbg) begin
         d_req_valid = 1; d_req_we = we; d_req_addr = addr; d_req_wdata = wd; d_rsp_ready = 1;
      end else begin
         c_req_valid = 1; c_req_we = we; c_req_addr = addr; c_req_wdata = wd; c_rsp_ready = 1;
      end
      wait_ready(dbg, name);
      step();
      if (dbg) d_req_valid = 0;
      else     c_req_valid = 0;
      @(negedge clk);
      check({name, "_acc"}, {mem_read, mem_write, mem_a, mem_wd[20:0]},
            {~we, we, addr, (we ? wd[20:0] : 21'h0)});
      check({name, "_wd"}, mem_wd, we ? wd : 32'h0);
      step();
      @(negedge clk);
      check({name, "_rspv"}, {30'h0, c_rsp_valid, d_rsp_valid}, dbg ? 32'd1 : 32'd2);
      check({name, "_rdata"}, dbg ? d_rsp_rdata : c_rsp_rdata, exp_rd);
      step();
   endtask

   typedef struct {
      bit          dbg;
      bit          we;
      logic [8:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [6];

   initial begin
      vecs[0] = '{0, 0, 9'h005, 32'h0,        32'hDEADBEEF};
      vecs[1] = '{1, 1, 9'h1FF, 32'hA5A5A5A5, 32'h0};
      vecs[2] = '{0, 0, 9'h1FF, 32'h0,        32'hA5A5A5A5};
      vecs[3] = '{0, 1, 9'h000, 32'h12345678, 32'h0};
      vecs[4] = '{1, 0, 9'h000, 32'h0,        32'h12345678};
      vecs[5] = '{1, 0, 9'h005, 32'h0,        32'hDEADBEEF};

      // Reset with DataMemory preload.
      #1;
      pl_en = 1; pl_a = 9'h005; pl_d = 32'hDEADBEEF;
      step();
      pl_en = 0;
      step();
      @(negedge clk);
      check("rst_ready", {c_req_ready, d_req_ready}, 0);
      check("rst_rspv", {c_rsp_valid, d_rsp_valid}, 0);
      check("rst_mem", {mem_read, mem_write, mem_a}, 0);
      check("rst_wd", mem_wd, 0);
      check("rst_rdata", c_rsp_rdata | d_rsp_rdata, 0);
      rst_n = 1;
      step();

      for (int i = 0; i < 6; i++) txn(vecs[i].dbg, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                                      vecs[i].exp_rd, $sformatf("vec%0d", i));
      check("write_pulses", wr_cnt, 2);

      // Simultaneous requests right after reset: debug wins the first round-robin tie.
      rst_n = 0;
      step();
      rst_n = 1;
      c_req_valid = 1; c_req_we = 1; c_req_addr = 9'h010; c_req_wdata = 32'h11;
      d_req_valid = 1; d_req_we = 0; d_req_addr = 9'h005;
      c_rsp_ready = 1; d_rsp_ready = 1;
      @(negedge clk);
      check("tie_first", {c_req_ready, d_req_ready}, 2'b01);
      step();
      d_req_valid = 0;
      @(negedge clk);
      check("tie_acc_noready", {c_req_ready, d_req_ready, mem_read}, 3'b001);
      step();
      @(negedge clk);
      check("tie_d_rsp", {c_rsp_valid, d_rsp_valid}, 2'b01);
      check("tie_d_rdata", d_rsp_rdata, 32'hDEADBEEF);
      step();
      @(negedge clk);
      check("tie_second", {c_req_ready, d_req_ready}, 2'b10);
      step();
      c_req_valid = 0;
      @(negedge clk);
      check("tie_c_acc", {mem_write, mem_a}, {1'b1, 9'h010});
      step();
      @(negedge clk);
      check("tie_c_rsp", {c_rsp_valid, d_rsp_valid, c_rsp_rdata}, {2'b10, 32'h0});
      step();

      // Response back-pressure: rdata held, no request accepted meanwhile.
      c_req_valid = 1; c_req_we = 0; c_req_addr = 9'h005; c_rsp_ready = 0;
      wait_ready(0, "bp");
      step();
      c_req_valid = 0;
      d_req_valid = 1; d_req_we = 0; d_req_addr = 9'h1FF;
      @(negedge clk);
      check("bp_acc_dready", d_req_ready, 0);
      step();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("bp_hold%0d", i), {c_rsp_valid, d_req_ready, c_rsp_rdata},
               {2'b10, 32'hDEADBEEF});
         step();
      end
      c_rsp_ready = 1;
      @(negedge clk);
      check("bp_release", c_rsp_valid, 1);
      step();
      @(negedge clk);
      check("bp_dbg_next", d_req_ready, 1);
      step();
      d_req_valid = 0;
      step();
      step();

      // Reset during RESP of a read: response dropped and never reissued.
      c_req_valid = 1; c_req_we = 0; c_req_addr = 9'h005; c_rsp_ready = 0;
      wait_ready(0, "rrsp");
      step();
      c_req_valid = 0;
      step();
      @(negedge clk);
      check("rrsp_pre", c_rsp_valid, 1);
      rst_n = 0;
      step();
      @(negedge clk);
      check("rrsp_rspv", {c_rsp_valid, d_rsp_valid}, 0);
      check("rrsp_mem", {mem_read, mem_write, mem_a}, 0);
      check("rrsp_wd_rdata", mem_wd | c_rsp_rdata, 0);
      rst_n = 1;
      c_rsp_ready = 1;
      begin
         int late = 0;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            late += int'(c_rsp_valid) + int'(d_rsp_valid) + int'(mem_read) + int'(mem_write);
         end
         check("rrsp_no_late", late, 0);
      end

      // Reset on the edge that ends a write's ACCESS cycle: the write still lands.
      step();
      c_req_valid = 1; c_req_we = 1; c_req_addr = 9'h020; c_req_wdata = 32'h00000077;
      wait_ready(0, "racc");
      step();
      c_req_valid = 0;
      rst_n = 0;
      @(negedge clk);
      check("racc_wr", mem_write, 1);
      step();
      rst_n = 1;
      @(negedge clk);
      check("racc_norsp", c_rsp_valid, 0);
      step();
      txn(0, 0, 9'h020, 32'h0, 32'h00000077, "racc_rd");

      // Fixed priority: core wins every tie; debug only after core withdraws.
      p_rst_n = 1;
      p_c_valid = 1; p_d_valid = 1;
      begin
         int cg = 0;
         int dg_early = 0;
         bit dg_late = 0;
         for (int i = 0; i < 60 && !dg_late; i++) begin
            @(negedge clk);
            if (p_d_ready) begin
               if (cg < 4) dg_early++;
               else        dg_late = 1;
            end
            if (p_c_ready) begin
               cg++;
               if (cg == 4) begin
                  step();
                  p_c_valid = 0;
               end
            end
         end
         check("fp_core_grants", cg, 4);
         check("fp_dbg_starved", dg_early, 0);
         check("fp_dbg_after", 32'(dg_late), 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
